// File: rtl/onewire_master_driver.sv
// 1-Wire master line driver: reset/presence, write slots and read slots on an
// open-drain line, standard or overdrive timing derived from a 100 ns tick.
module onewire_master_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TICK_DIV   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_write,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_overdrive,
  inout  wire                   bus,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_presence,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TW = 13;

  typedef logic [TW-1:0] tim_t;

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, SLOT_REC, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pre_q, pre_d;
  tim_t                  timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rd_q, rd_d;
  logic                  ovd_q, ovd_d;
  logic                  pres_q, pres_d;
  logic                  drive_q;
  logic [1:0]            sync_q;

  logic tick;
  tim_t tnext;
  tim_t t_rstl, t_rsth, t_pds, t_low, t_sample, t_slot, t_rec;

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign tnext = timer_q + 1'b1;

  // Phase lengths in ticks for the selected speed
  always_comb begin
    t_rstl   = ovd_q ? tim_t'(700) : tim_t'(4800);
    t_rsth   = ovd_q ? tim_t'(700) : tim_t'(4800);
    t_pds    = ovd_q ? tim_t'(85)  : tim_t'(700);
    t_sample = ovd_q ? tim_t'(20)  : tim_t'(150);
    t_slot   = ovd_q ? tim_t'(100) : tim_t'(700);
    t_rec    = ovd_q ? tim_t'(25)  : tim_t'(100);
    if (!rd_q && !shift_q[0]) t_low = ovd_q ? tim_t'(75) : tim_t'(600);
    else                      t_low = ovd_q ? tim_t'(10) : tim_t'(60);
  end

  // Next-state logic; phases only advance on a tick so each phase is whole ticks
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rd_d    = rd_q;
    ovd_d   = ovd_q;
    pres_d  = pres_q;
    if (state_q != IDLE) pre_d = tick ? '0 : pre_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        pre_d   = '0;
        timer_d = '0;
        bit_d   = '0;
        if (i_start) begin
          state_d = RST_LOW;
          ovd_d   = i_overdrive;
        end else if (i_write) begin
          state_d = SLOT_LOW;
          ovd_d   = i_overdrive;
          shift_d = i_data;
          rd_d    = 1'b0;
        end else if (i_read) begin
          state_d = SLOT_LOW;
          ovd_d   = i_overdrive;
          shift_d = '0;
          rd_d    = 1'b1;
        end
      end
      RST_LOW: if (tick) begin
        timer_d = tnext;
        if (tnext == t_rstl) begin
          state_d = RST_HIGH;
          timer_d = '0;
        end
      end
      RST_HIGH: if (tick) begin
        timer_d = tnext;
        if (tnext == t_pds) pres_d = ~sync_q[1];
        if (tnext == t_rsth) begin
          state_d = DONE;
          timer_d = '0;
        end
      end
      // Timer runs from slot start through SLOT_HIGH so tSLOT/tSAMPLE are absolute
      SLOT_LOW: if (tick) begin
        timer_d = tnext;
        if (tnext == t_low) state_d = SLOT_HIGH;
      end
      SLOT_HIGH: if (tick) begin
        timer_d = tnext;
        if (rd_q && tnext == t_sample) begin
          shift_d = shift_q >> 1;
          shift_d[DATA_WIDTH-1] = sync_q[1];
        end
        if (tnext == t_slot) begin
          state_d = SLOT_REC;
          timer_d = '0;
        end
      end
      SLOT_REC: if (tick) begin
        timer_d = tnext;
        if (tnext == t_rec) begin
          timer_d = '0;
          if (!rd_q) shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = DONE;
            if (rd_q) data_d = shift_q;
          end else begin
            state_d = SLOT_LOW;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pre_d   = '0;
        timer_d = '0;
        bit_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, line driver (one cycle behind state) and input synchroniser
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      ovd_q   <= 1'b0;
      pres_q  <= 1'b0;
      drive_q <= 1'b0;
      sync_q  <= '1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ovd_q   <= ovd_d;
      pres_q  <= pres_d;
      drive_q <= (state_q == RST_LOW) || (state_q == SLOT_LOW);
      sync_q  <= {sync_q[0], bus};
    end
  end

  assign bus        = drive_q ? 1'b0 : 1'bz;
  assign o_data     = data_q;
  assign o_presence = pres_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_onewire_master_driver.sv
// Self-checking bench for onewire_master_driver with a pull-up and a slave model.
module tb_onewire_master_driver;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_start = 1'b0, i_write = 1'b0, i_read = 1'b0, i_overdrive = 1'b0;
  logic [DW-1:0] i_data = '0;
  wire           bus;
  logic [DW-1:0] o_data;
  logic          o_presence, o_busy, o_done;
  logic          slave_low = 1'b0;

  pullup (bus);
  assign bus = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  onewire_master_driver #(.DATA_WIDTH(DW), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_write(i_write), .i_read(i_read),
    .i_data(i_data), .i_overdrive(i_overdrive), .bus(bus), .o_data(o_data),
    .o_presence(o_presence), .o_busy(o_busy), .o_done(o_done)
  );

  int unsigned total = 0, bad = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference timing in ticks, index 0 = standard, 1 = overdrive
  int unsigned T_RSTL[2]  = '{4800, 700};
  int unsigned T_RSTH[2]  = '{4800, 700};
  int unsigned T_LOW0[2]  = '{600, 75};
  int unsigned T_LOW1[2]  = '{60, 10};
  int unsigned T_SLOT[2]  = '{700, 100};
  int unsigned T_REC[2]   = '{100, 25};
  int unsigned T_SHOLD[2] = '{300, 40};

  // Line monitor: low-pulse widths, fall times, done pulses
  int unsigned cyc = 0, low_run = 0, dones = 0;
  int unsigned lows[$];
  int unsigned falls[$];
  logic prev_line = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (bus == 1'b0) begin
      if (prev_line) falls.push_back(cyc);
      low_run++;
      prev_line = 1'b0;
    end else begin
      if (!prev_line) lows.push_back(low_run);
      low_run = 0;
      prev_line = 1'b1;
    end
    if (o_done) dones++;
  end

  // Slave: 0 = absent, 1 = answers reset with presence, 2 = sends rd_bits LSB first
  int          slave_mode = 0;
  int unsigned pres_delay = 150;
  logic [DW-1:0] rd_bits = '0;
  int unsigned rd_idx = 0;
  int unsigned slv_ovd = 0;
  initial begin
    forever begin
      @(negedge bus);
      if (slave_mode == 2) begin
        if (rd_bits[rd_idx] == 1'b0) begin
          slave_low = 1'b1;
          repeat (T_SHOLD[slv_ovd]) @(posedge clk);
          slave_low = 1'b0;
        end
        rd_idx++;
      end else if (slave_mode == 1) begin
        @(posedge bus);
        repeat (pres_delay) @(posedge clk);
        slave_low = 1'b1;
        repeat (600) @(posedge clk);
        slave_low = 1'b0;
      end
    end
  end

  // kind: 0 start, 1 write, 2 read, 3 start+write together
  task automatic run_cmd(input int kind, input logic [DW-1:0] d, input logic ovd,
                         input bit poke_read, output int unsigned lat);
    @(negedge clk);
    lows.delete();
    falls.delete();
    dones = 0;
    rd_idx = 0;
    slv_ovd = ovd ? 1 : 0;
    i_start     = (kind == 0 || kind == 3);
    i_write     = (kind == 1 || kind == 3);
    i_read      = (kind == 2);
    i_data      = d;
    i_overdrive = ovd;
    @(negedge clk);
    i_start = 1'b0; i_write = 1'b0; i_read = 1'b0;
    check("busy_after_accept", o_busy, 1);
    check("bus_latency", bus, 1);
    lat = 1;
    while (!o_done && lat < 20000) begin
      @(negedge clk);
      lat++;
      if (poke_read && lat == 100) i_read = 1'b1;
      else i_read = 1'b0;
    end
    i_read = 1'b0;
    if (!o_done) check("done_timeout", 0, 1);
    check("busy_at_done", o_busy, 1);
    repeat (20) @(negedge clk);
    check("single_done", dones, 1);
    check("idle_after_done", o_busy, 0);
  endtask

  task automatic check_write(input logic [DW-1:0] d, input int o, input int unsigned lat);
    check("wr_latency", lat, DW * (T_SLOT[o] + T_REC[o]) + 1);
    check("wr_nslots", lows.size(), DW);
    for (int i = 0; i < DW && i < lows.size(); i++)
      check($sformatf("wr_low%0d", i), lows[i], ((d >> i) & 1) ? T_LOW1[o] : T_LOW0[o]);
    for (int i = 1; i < DW && i < falls.size(); i++)
      check($sformatf("wr_period%0d", i), falls[i] - falls[i-1], T_SLOT[o] + T_REC[o]);
  endtask

  int unsigned   lat;
  logic          exp_pres;
  logic [DW-1:0] exp_data, wd;
  int unsigned   guard;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_pres", o_presence, 0);
    check("rst_data", o_data, 0);
    check("rst_bus", bus, 1);
    exp_data = '0;

    // Reset sequence without slave, then with one
    slave_mode = 0;
    run_cmd(0, '0, 1'b0, 0, lat);
    check("rstseq_lat", lat, T_RSTL[0] + T_RSTH[0] + 1);
    check("rstseq_low", lows.size() > 0 ? lows[0] : 0, T_RSTL[0]);
    check("pres_absent", o_presence, 0);
    slave_mode = 1;
    pres_delay = $urandom_range(100, 300);
    run_cmd(0, '0, 1'b0, 0, lat);
    check("rstseq_lat2", lat, T_RSTL[0] + T_RSTH[0] + 1);
    check("pres_seen", o_presence, 1);
    exp_pres = 1'b1;
    slave_mode = 0;

    // Writes: fixed pattern, random standard, overdrive all-ones, random overdrive
    run_cmd(1, 8'hA5, 1'b0, 0, lat);
    check_write(8'hA5, 0, lat);
    check("wr_pres_kept", o_presence, exp_pres);
    wd = DW'($urandom);
    run_cmd(1, wd, 1'b0, 0, lat);
    check_write(wd, 0, lat);
    run_cmd(1, 8'hFF, 1'b1, 0, lat);
    check_write(8'hFF, 1, lat);
    wd = DW'($urandom);
    run_cmd(1, wd, 1'b1, 0, lat);
    check_write(wd, 1, lat);
    check("wr_data_kept", o_data, exp_data);

    // Reads
    slave_mode = 2;
    rd_bits = 8'h3C;
    run_cmd(2, '0, 1'b0, 0, lat);
    exp_data = 8'h3C;
    check("rd_std", o_data, exp_data);
    check("rd_nslots", falls.size(), DW);
    check("rd_latency", lat, DW * (T_SLOT[0] + T_REC[0]) + 1);
    rd_bits = DW'($urandom);
    run_cmd(2, '0, 1'b1, 0, lat);
    exp_data = rd_bits;
    check("rd_ovd", o_data, exp_data);
    check("rd_pres_kept", o_presence, exp_pres);
    slave_mode = 0;

    // Simultaneous start+write: reset only; read pulsed while busy is dropped
    run_cmd(3, 8'h00, 1'b0, 1, lat);
    check("prio_lat", lat, T_RSTL[0] + T_RSTH[0] + 1);
    check("prio_nlows", lows.size(), 1);
    check("prio_pres", o_presence, 0);
    check("prio_data_kept", o_data, exp_data);

    // Abort a write during bit 3
    @(negedge clk);
    lows.delete(); falls.delete();
    i_data = DW'($urandom); i_write = 1'b1; i_overdrive = 1'b0;
    @(negedge clk);
    i_write = 1'b0;
    guard = 0;
    while (falls.size() < 4 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reach_bit3", falls.size(), 4);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_bus", bus, 1);
    check("abort_busy", o_busy, 0);
    check("abort_data", o_data, 0);
    check("abort_pres", o_presence, 0);
    dones = 0;
    repeat (1500) @(negedge clk);
    check("abort_no_done", dones, 0);
    wd = DW'($urandom);
    run_cmd(1, wd, 1'b0, 0, lat);
    check_write(wd, 0, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
